// File: rtl/noc_mem_responder_pkg.sv
// rtl/noc_mem_responder_pkg.sv - shared flit layout, message types and responder state
package noc_mem_responder_pkg;

    localparam int NUM_CORES   = 4;
    localparam int VC_COUNT    = 3;
    localparam int FLIT_WIDTH  = 128;
    localparam int ADDR_WIDTH  = 48;
    localparam int DATA_WIDTH  = 64;
    localparam int MEM_SIZE_MB = 1024;

    localparam int MSG_W  = 3;
    localparam int NODE_W = 2;
    localparam int VC_W   = 2;
    localparam int TXN_W  = 7;

    // Message types; RESP_* and 3'b111 are never legal as requests.
    localparam logic [MSG_W-1:0] REQ_READ       = 3'd0;
    localparam logic [MSG_W-1:0] REQ_READ_EXCL  = 3'd1;
    localparam logic [MSG_W-1:0] REQ_WRITE      = 3'd2;
    localparam logic [MSG_W-1:0] REQ_INVALIDATE = 3'd3;
    localparam logic [MSG_W-1:0] RESP_DATA      = 3'd4;
    localparam logic [MSG_W-1:0] RESP_DATA_EXCL = 3'd5;
    localparam logic [MSG_W-1:0] RESP_ACK       = 3'd6;

    // Flit field positions, shared by requests and responses.
    localparam int MSG_MSB  = 127;
    localparam int MSG_LSB  = 125;
    localparam int SRC_MSB  = 124;
    localparam int SRC_LSB  = 123;
    localparam int DST_MSB  = 122;
    localparam int DST_LSB  = 121;
    localparam int VC_MSB   = 120;
    localparam int VC_LSB   = 119;
    localparam int TXN_MSB  = 118;
    localparam int TXN_LSB  = 112;
    localparam int ADDR_MSB = 111;
    localparam int ADDR_LSB = 64;
    localparam int DATA_MSB = 63;
    localparam int DATA_LSB = 0;

    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES_DEFAULT = ADDR_WIDTH'(MEM_SIZE_MB) << 20;

    // Data word returned with RESP_ACK when the address was out of range.
    localparam logic [DATA_WIDTH-1:0] RESP_ERR_ADDR = 64'h1;

    typedef struct packed {
        logic [MSG_W-1:0]      msg_type;
        logic [NODE_W-1:0]     src;
        logic [NODE_W-1:0]     dst;
        logic [VC_W-1:0]       vc;
        logic [TXN_W-1:0]      txn;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } noc_flit_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } resp_state_t;

    function automatic noc_flit_t make_resp(
        input logic [MSG_W-1:0]      msg_type,
        input logic [NODE_W-1:0]     src,
        input logic [NODE_W-1:0]     dst,
        input logic [VC_W-1:0]       vc,
        input logic [TXN_W-1:0]      txn,
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [DATA_WIDTH-1:0] data
    );
        noc_flit_t f;
        f.msg_type = msg_type;
        f.src      = src;
        f.dst      = dst;
        f.vc       = vc;
        f.txn      = txn;
        f.addr     = addr;
        f.data     = data;
        return f;
    endfunction

endpackage

// File: rtl/noc_mem_responder_codec.sv
// rtl/noc_mem_responder_codec.sv - combinational pack/unpack between noc_flit_t and the flit vector
module noc_flit_codec
    import noc_mem_responder_pkg::*;
(
    input  noc_flit_t             pack_fields,
    output logic [FLIT_WIDTH-1:0] pack_flit,
    input  logic [FLIT_WIDTH-1:0] unpack_flit,
    output noc_flit_t             unpack_fields
);

    // Place each struct field at its wire position.
    always_comb begin
        pack_flit                    = '0;
        pack_flit[MSG_MSB:MSG_LSB]   = pack_fields.msg_type;
        pack_flit[SRC_MSB:SRC_LSB]   = pack_fields.src;
        pack_flit[DST_MSB:DST_LSB]   = pack_fields.dst;
        pack_flit[VC_MSB:VC_LSB]     = pack_fields.vc;
        pack_flit[TXN_MSB:TXN_LSB]   = pack_fields.txn;
        pack_flit[ADDR_MSB:ADDR_LSB] = pack_fields.addr;
        pack_flit[DATA_MSB:DATA_LSB] = pack_fields.data;
    end

    // Pull each field out of its wire position.
    always_comb begin
        unpack_fields          = '0;
        unpack_fields.msg_type = unpack_flit[MSG_MSB:MSG_LSB];
        unpack_fields.src      = unpack_flit[SRC_MSB:SRC_LSB];
        unpack_fields.dst      = unpack_flit[DST_MSB:DST_LSB];
        unpack_fields.vc       = unpack_flit[VC_MSB:VC_LSB];
        unpack_fields.txn      = unpack_flit[TXN_MSB:TXN_LSB];
        unpack_fields.addr     = unpack_flit[ADDR_MSB:ADDR_LSB];
        unpack_fields.data     = unpack_flit[DATA_MSB:DATA_LSB];
    end

endmodule

// File: rtl/noc_mem_responder.sv
// rtl/noc_mem_responder.sv - home-node memory responder, one coherence transaction at a time
module noc_mem_responder
    import noc_mem_responder_pkg::*;
#(
    parameter int unsigned           NODE_ID   = 0,
    parameter logic [ADDR_WIDTH-1:0] MEM_BYTES = MEM_BYTES_DEFAULT,
    parameter int unsigned           RESP_VC   = VC_COUNT - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] req_flit,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [FLIT_WIDTH-1:0] resp_flit,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_pulse,
    output logic [15:0]           resp_count
);

    localparam logic [NODE_W-1:0] SELF_ID = NODE_W'(NODE_ID);
    localparam logic [VC_W-1:0]   VC_ID   = VC_W'(RESP_VC);

    resp_state_t state;
    resp_state_t state_next;

    noc_flit_t req_f;
    noc_flit_t resp_q;

    logic [MSG_W-1:0]      lat_type;
    logic [NODE_W-1:0]     lat_src;
    logic [TXN_W-1:0]      lat_txn;
    logic [ADDR_WIDTH-1:0] lat_addr;

    logic accept;
    logic is_read;
    logic is_write;
    logic is_inval;
    logic is_legal;
    logic addr_ok;
    logic unused_route;

    noc_flit_codec u_codec (
        .pack_fields   (resp_q),
        .pack_flit     (resp_flit),
        .unpack_flit   (req_flit),
        .unpack_fields (req_f)
    );

    // dst and vc of a request are the router's concern; the flit is serviced regardless.
    assign unused_route = ^{req_f.dst, req_f.vc};

    // Classify the incoming request.
    always_comb begin
        accept   = req_valid && req_ready;
        is_read  = (req_f.msg_type == REQ_READ) || (req_f.msg_type == REQ_READ_EXCL);
        is_write = (req_f.msg_type == REQ_WRITE);
        is_inval = (req_f.msg_type == REQ_INVALIDATE);
        is_legal = is_read || is_write || is_inval;
        addr_ok  = (req_f.addr < MEM_BYTES);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the handshake strobes that follow directly from the state.
    always_comb begin
        state_next    = state;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_read || is_write) begin
                        state_next = addr_ok ? ST_MEM_REQ : ST_RESP;
                    end else if (is_inval) begin
                        state_next = ST_RESP;
                    end
                end
            end
            ST_MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = (lat_type == REQ_WRITE) ? ST_RESP : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rvalid) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latching, memory command, response build and counters.
    // req_ready is registered so it reads 0 while rst is held and rises only once IDLE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b0;
            err_pulse  <= 1'b0;
            resp_count <= '0;
            resp_q     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_type   <= '0;
            lat_src    <= '0;
            lat_txn    <= '0;
            lat_addr   <= '0;
        end else begin
            req_ready <= (state_next == ST_IDLE);
            err_pulse <= accept && !is_legal;
            unique case (state)
                ST_IDLE: begin
                    if (accept && is_legal) begin
                        lat_type <= req_f.msg_type;
                        lat_src  <= req_f.src;
                        lat_txn  <= req_f.txn;
                        lat_addr <= req_f.addr;
                        if ((is_read || is_write) && addr_ok) begin
                            mem_we    <= is_write;
                            mem_addr  <= {req_f.addr[ADDR_WIDTH-1:3], 3'b000};
                            mem_wdata <= is_write ? req_f.data : '0;
                        end else begin
                            resp_q <= make_resp(RESP_ACK, SELF_ID, req_f.src, VC_ID, req_f.txn,
                                                req_f.addr, is_inval ? '0 : RESP_ERR_ADDR);
                        end
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_req_ready && (lat_type == REQ_WRITE)) begin
                        resp_q <= make_resp(RESP_ACK, SELF_ID, lat_src, VC_ID, lat_txn,
                                            lat_addr, '0);
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rvalid) begin
                        resp_q <= make_resp((lat_type == REQ_READ_EXCL) ? RESP_DATA_EXCL : RESP_DATA,
                                            SELF_ID, lat_src, VC_ID, lat_txn, lat_addr, mem_rdata);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_count <= resp_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
